xy2_100_tx: RTL and testbench
=============================

# xy2_100_tx

Serial transmitter for the XY2-100 galvo interface; it is the consumer of the coordinate stream produced by the raster-scan generator. It accepts a 16-bit X/Y coordinate pair on each rising edge of the scan block's `xy2_send` strobe and buffers it in a one-deep holding register. It streams continuous 20-bit XY2-100 frames on the `sclk`, `sync`, `x_out` and `y_out` pins. Each frame carries the most recently accepted coordinate.

## Interface
- `HALF_DIV`, 25: system clocks per `sclk` half period. Must be ≥2. At 100 MHz, 25 gives a 2 MHz `sclk`.
- `RESET_COORD`, 16'h8000: holding-register reset value (galvo centre).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `enable` in 1: level; stream frames while high.
- `x_coord` in 16: X coordinate, sampled on a `xy2_send` rising edge.
- `y_coord` in 16: Y coordinate, sampled on a `xy2_send` rising edge.
- `xy2_send` in 1: level strobe from the scan block; only its rising edge is used.
- `pending` out 1: holding register contains a coordinate not yet loaded into a frame.
- `coord_ack` out 1: one-cycle pulse when a pending coordinate is loaded into a frame.
- `overrun` out 1: one-cycle pulse when a new coordinate overwrites a pending one.
- `sclk` out 1: XY2 clock.
- `sync` out 1: XY2 sync.
- `x_out` out 1: XY2 X-channel data.
- `y_out` out 1: XY2 Y-channel data.

## Operation
- **Edge detect:** `send_d` is a 1-cycle delay of `xy2_send`. Capture happens on cycles where `xy2_send & ~send_d`. On capture, `x_coord`/`y_coord` load into `xh`/`yh` that same edge and `pending` is set.
- **Overrun:** a capture while `pending` is already 1 overwrites `xh`/`yh` and pulses `overrun`. The newest value is the one transmitted.
- **Frame format:** 20 bits, MSB first: C2 C1 C0 = 0,0,1, then D15..D0, then P.
  - P is even parity over the 19 preceding bits: P = 1 ^ (^D).
  - X and Y frames are independent shift registers with identical timing.
- **FSM states:** IDLE, RUN.
- **IDLE:**
  - `sclk`=0, `sync`=0, `x_out`=0, `y_out`=0.
  - When `enable`=1: go to RUN and do a frame load.
- **RUN:**
  - `div_cnt` counts 0..2·HALF_DIV−1; `bit_cnt` counts 0..19.
  - `sclk` = (div_cnt < HALF_DIV).
  - Data and `sync` change only when `div_cnt` wraps to 0, i.e. at the `sclk` rising edge. The receiver samples at the `sclk` falling edge.
  - `sync`=1 for bits 0..18 and 0 for bit 19.
  - When bit 19 finishes: if `enable`=1, do a frame load (back-to-back frames, no gap); otherwise go to IDLE.
  - A frame is never truncated by `enable` falling.
- **Frame load:**
  - Shift registers ← {3'b001, xh/yh, parity}.
  - If `pending`: clear it and pulse `coord_ack`.
  - If an unrelated capture happens in the same cycle as a frame load, the frame uses the old `xh`/`yh`. The new value is captured, `pending` stays/becomes 1, and no `coord_ack` pulses.
- **When no new coordinate arrives:** each frame repeats the last held value.

## Timing
- All outputs are registered.
- Reset values: `sclk`, `sync`, `x_out`, `y_out`, `pending`, `coord_ack`, `overrun` = 0. `xh` = `yh` = RESET_COORD; state = IDLE.
- Latency from `enable` to the line:
  - `enable` is sampled high at edge N in IDLE.
  - After edge N, bit 0 is on the outputs with `sclk`=1 and `sync`=1.
- Bit period is 2·HALF_DIV cycles; frame period is 40·HALF_DIV cycles (1000 at the default).
- Capture latency: `pending` rises one edge after the cycle in which `xy2_send` rises.
- `coord_ack` is coincident with bit 0 of the frame carrying the value.
- Reset asserted mid-frame forces all reset values immediately. The line restarts at bit 0 only after reset is released and `enable` is sampled high.

## Test plan
- **Reset state:** assert reset → all outputs 0, state IDLE. Release reset with `enable`=0 for 100 cycles → line stays idle.
- **Default frame:** HALF_DIV=2, `enable`=1, no send → `x_out` bits 0,0,1,1, then 15×0, then P=0. `sync` is high for 76 cycles then low for 4. Frames repeat every 80 cycles with no gap.
- **Mid-frame capture:** during bit 5, raise `xy2_send` with x=16'h1234, y=16'hFFFF → `pending`=1 on the next edge. The current frame still sends 16'h8000. The next frame sends X data 0x1234 with P=0 and Y data 0xFFFF with P=1; `coord_ack` pulses at its bit 0 and `pending` clears.
- **Overrun:** two rising edges in one frame (0x0001, then 0x0002) → one `overrun` pulse on the second edge. The next frame carries 0x0002 (P=0); exactly one `coord_ack`.
- **Capture at frame load:** raise `xy2_send` in the frame-load cycle → the loaded frame carries the old value with no `coord_ack`. The following frame carries the new value with `coord_ack`.
- **Enable drop and reset:**
  - Drop `enable` at bit 10 → the frame completes all 20 bits, then the line returns to idle (all 0).
  - Assert reset at bit 7 → outputs 0 immediately and the holding registers return to 0x8000.

Source files
------------

// File: rtl/xy2_100_tx.sv
// ---------------------------------------------------------------------------
// xy2_100_tx
// Serial transmitter for the XY2-100 galvo interface. Coordinates arrive from
// the raster-scan generator on rising edges of xy2_send and are held in a
// one-deep holding register. While enable is high the block streams
// back-to-back 20-bit frames (0,0,1, D15..D0, even parity) on x_out/y_out,
// always carrying the most recently accepted coordinate.
//
// Parameters:
//   HALF_DIV     system clocks per sclk half period (>= 2)
//   RESET_COORD  holding-register value after reset (galvo centre)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   enable     in   stream frames while high
//   x_coord    in   X coordinate, sampled on an xy2_send rising edge
//   y_coord    in   Y coordinate, sampled on an xy2_send rising edge
//   xy2_send   in   level strobe; only its rising edge is used
//   pending    out  holding register has a coordinate not yet framed
//   coord_ack  out  one-cycle pulse when a pending coordinate is framed
//   overrun    out  one-cycle pulse when a pending coordinate is overwritten
//   sclk       out  XY2 clock
//   sync       out  XY2 sync
//   x_out      out  XY2 X-channel data
//   y_out      out  XY2 Y-channel data
// ---------------------------------------------------------------------------
module xy2_100_tx #(
  parameter int          HALF_DIV    = 25,
  parameter logic [15:0] RESET_COORD = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] x_coord,
  input  logic [15:0] y_coord,
  input  logic        xy2_send,
  output logic        pending,
  output logic        coord_ack,
  output logic        overrun,
  output logic        sclk,
  output logic        sync,
  output logic        x_out,
  output logic        y_out
);

  localparam int DIV_LAST = 2 * HALF_DIV - 1;
  localparam int DIV_W    = $clog2(2 * HALF_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   divCnt_q;
  logic [4:0]         bitCnt_q;
  logic [19:0]        xShift_q;
  logic [19:0]        yShift_q;
  logic [15:0]        xHold_q;
  logic [15:0]        yHold_q;
  logic               sendDly_q;
  logic               pending_q;
  logic               coordAck_q;
  logic               overrun_q;
  logic               sclk_q;
  logic               sync_q;
  logic               xOut_q;
  logic               yOut_q;

  logic               capture;
  logic [19:0]        xFrame;
  logic [19:0]        yFrame;
  logic [DIV_W-1:0]   divNext;
  logic               bitEnd;
  logic               frameEnd;
  logic               doLoad;

  // Frame words are built from the current holding registers, so a capture
  // landing on the load edge only affects the following frame.
  always_comb begin
    capture  = xy2_send & ~sendDly_q;
    xFrame   = {3'b001, xHold_q, ~(^xHold_q)};
    yFrame   = {3'b001, yHold_q, ~(^yHold_q)};
    divNext  = divCnt_q + DIV_W'(1);
    bitEnd   = (state_q == RUN) && (divCnt_q == DIV_W'(DIV_LAST));
    frameEnd = bitEnd && (bitCnt_q == 5'd19);
    doLoad   = enable && ((state_q == IDLE) || frameEnd);
  end

  // Holding register, edge detect and the pending/ack/overrun handshake.
  // An ack is withheld when a fresh capture coincides with a frame load,
  // since the frame being loaded carries the older coordinate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sendDly_q  <= 1'b0;
      xHold_q    <= RESET_COORD;
      yHold_q    <= RESET_COORD;
      pending_q  <= 1'b0;
      coordAck_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sendDly_q  <= xy2_send;
      coordAck_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (capture) begin
        xHold_q   <= x_coord;
        yHold_q   <= y_coord;
        pending_q <= 1'b1;
        overrun_q <= pending_q;
      end else if (doLoad && pending_q) begin
        pending_q  <= 1'b0;
        coordAck_q <= 1'b1;
      end
    end
  end

  // Line FSM. Data and sync only change when the divider wraps, which is
  // also where sclk rises; the receiver samples on the falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      xShift_q <= '0;
      yShift_q <= '0;
      sclk_q   <= 1'b0;
      sync_q   <= 1'b0;
      xOut_q   <= 1'b0;
      yOut_q   <= 1'b0;
    end else begin
      if (doLoad) begin
        state_q  <= RUN;
        divCnt_q <= '0;
        bitCnt_q <= '0;
        xShift_q <= {xFrame[18:0], 1'b0};
        yShift_q <= {yFrame[18:0], 1'b0};
        sclk_q   <= 1'b1;
        sync_q   <= 1'b1;
        xOut_q   <= xFrame[19];
        yOut_q   <= yFrame[19];
      end else begin
        case (state_q)
          IDLE: begin
            sclk_q <= 1'b0;
            sync_q <= 1'b0;
            xOut_q <= 1'b0;
            yOut_q <= 1'b0;
          end
          RUN: begin
            if (frameEnd) begin
              state_q  <= IDLE;
              divCnt_q <= '0;
              bitCnt_q <= '0;
              sclk_q   <= 1'b0;
              sync_q   <= 1'b0;
              xOut_q   <= 1'b0;
              yOut_q   <= 1'b0;
            end else if (bitEnd) begin
              divCnt_q <= '0;
              bitCnt_q <= bitCnt_q + 5'd1;
              xShift_q <= {xShift_q[18:0], 1'b0};
              yShift_q <= {yShift_q[18:0], 1'b0};
              sclk_q   <= 1'b1;
              sync_q   <= (bitCnt_q != 5'd18);
              xOut_q   <= xShift_q[19];
              yOut_q   <= yShift_q[19];
            end else begin
              divCnt_q <= divNext;
              sclk_q   <= (divNext < DIV_W'(HALF_DIV));
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pending   = pending_q;
  assign coord_ack = coordAck_q;
  assign overrun   = overrun_q;
  assign sclk      = sclk_q;
  assign sync      = sync_q;
  assign x_out     = xOut_q;
  assign y_out     = yOut_q;

endmodule

// File: tb/tb_xy2_100_tx.sv
// ---------------------------------------------------------------------------
// tb_xy2_100_tx
// Directed bench for xy2_100_tx with HALF_DIV=2 (4 clocks per bit, 80 per
// frame). Every cycle of every frame is compared against hand-written frame
// contents: sclk phase, sync, X/Y data bit, coord_ack, overrun and pending.
// ---------------------------------------------------------------------------
module tb_xy2_100_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] x_coord;
  logic [15:0] y_coord;
  logic        xy2_send;
  logic        pending;
  logic        coord_ack;
  logic        overrun;
  logic        sclk;
  logic        sync;
  logic        x_out;
  logic        y_out;

  int checkCount;
  int errorCount;

  // Bench-side expectations for the handshake outputs.
  logic expPend;
  logic expOv;

  xy2_100_tx #(
    .HALF_DIV   (2),
    .RESET_COORD(16'h8000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .x_coord  (x_coord),
    .y_coord  (y_coord),
    .xy2_send (xy2_send),
    .pending  (pending),
    .coord_ack(coord_ack),
    .overrun  (overrun),
    .sclk     (sclk),
    .sync     (sync),
    .x_out    (x_out),
    .y_out    (y_out)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Idle line check: everything low, pending as the bench expects.
  task automatic checkIdle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checkOutput($sformatf("%s line c%0d", tag, i),
                  {28'd0, sclk, sync, x_out, y_out}, 32'd0);
      checkOutput($sformatf("%s ack/ov c%0d", tag, i),
                  {30'd0, coord_ack, overrun}, 32'd0);
      checkOutput($sformatf("%s pending c%0d", tag, i), {31'd0, pending},
                  {31'd0, expPend});
      applyStimulus();
    end
  endtask

  // Check one full frame, entered at bit 0 cycle 0. Optional action:
  //   1 single capture of (ax,ay) at bit actBit
  //   2 capture (ax,ay) at actBit, then (bx,by) at actBit+4 (overrun)
  //   3 capture (ax,ay) so that it lands on the next frame-load edge
  //   4 drop enable at bit actBit
  //   5 assert reset at bit actBit and abandon the frame
  task automatic runFrame(input string tag,
                          input logic [15:0] xd, input logic xp,
                          input logic [15:0] yd, input logic yp,
                          input logic expAck, input int kind, input int actBit,
                          input logic [15:0] ax, input logic [15:0] ay,
                          input logic [15:0] bx, input logic [15:0] by);
    logic [19:0] xf;
    logic [19:0] yf;
    xf = {3'b001, xd, xp};
    yf = {3'b001, yd, yp};
    if (expAck) expPend = 1'b0;
    for (int b = 0; b < 20; b++) begin
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("%s sclk b%0d c%0d", tag, b, c), {31'd0, sclk},
                    {31'd0, (c < 2)});
        checkOutput($sformatf("%s sync b%0d c%0d", tag, b, c), {31'd0, sync},
                    {31'd0, (b < 19)});
        checkOutput($sformatf("%s x b%0d c%0d", tag, b, c), {31'd0, x_out},
                    {31'd0, xf[19-b]});
        checkOutput($sformatf("%s y b%0d c%0d", tag, b, c), {31'd0, y_out},
                    {31'd0, yf[19-b]});
        checkOutput($sformatf("%s ack b%0d c%0d", tag, b, c), {31'd0, coord_ack},
                    {31'd0, (b == 0 && c == 0) ? expAck : 1'b0});
        checkOutput($sformatf("%s overrun b%0d c%0d", tag, b, c), {31'd0, overrun},
                    {31'd0, expOv});
        checkOutput($sformatf("%s pending b%0d c%0d", tag, b, c), {31'd0, pending},
                    {31'd0, expPend});
        expOv = 1'b0;
        if (b == 0 && c == 0) xy2_send = 1'b0;
        if ((kind == 1 || kind == 2) && b == actBit && c == 0) begin
          x_coord = ax; y_coord = ay; xy2_send = 1'b1; expPend = 1'b1;
        end
        if ((kind == 1 || kind == 2) && b == actBit && c == 1) xy2_send = 1'b0;
        if (kind == 2 && b == actBit + 4 && c == 0) begin
          x_coord = bx; y_coord = by; xy2_send = 1'b1; expOv = 1'b1;
        end
        if (kind == 2 && b == actBit + 4 && c == 1) xy2_send = 1'b0;
        if (kind == 3 && b == 19 && c == 3) begin
          x_coord = ax; y_coord = ay; xy2_send = 1'b1; expPend = 1'b1;
        end
        if (kind == 4 && b == actBit && c == 0) enable = 1'b0;
        if (kind == 5 && b == actBit && c == 0) begin
          reset = 1'b1;
          expPend = 1'b0;
          #1;
          checkOutput($sformatf("%s reset line", tag),
                      {28'd0, sclk, sync, x_out, y_out}, 32'd0);
          checkOutput($sformatf("%s reset flags", tag),
                      {29'd0, pending, coord_ack, overrun}, 32'd0);
          return;
        end
        applyStimulus();
      end
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    expPend    = 1'b0;
    expOv      = 1'b0;
    reset      = 1'b1;
    enable     = 1'b0;
    x_coord    = 16'h0000;
    y_coord    = 16'h0000;
    xy2_send   = 1'b0;

    // Reset state, then 100 idle cycles with enable low.
    #1;
    checkOutput("reset async line", {28'd0, sclk, sync, x_out, y_out}, 32'd0);
    applyStimulus();
    applyStimulus();
    checkIdle("in reset", 2);
    reset = 1'b0;
    checkIdle("idle", 100);

    // Default frames; enable sampled on the next edge, bit 0 right after.
    enable = 1'b1;
    applyStimulus();
    runFrame("dflt1", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);

    // Mid-frame capture at bit 5; current frame keeps 0x8000.
    runFrame("midcap", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1, 5,
             16'h1234, 16'hFFFF, 0, 0);
    runFrame("new1234", 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);

    // Overrun: 0x0001 then 0x0002 within one frame.
    runFrame("ovr", 16'h1234, 1'b0, 16'hFFFF, 1'b1, 1'b0, 2, 5,
             16'h0001, 16'h0001, 16'h0002, 16'h0002);
    runFrame("new0002", 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);

    // Capture on the frame-load edge: loaded frame keeps the old value.
    runFrame("preload", 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0, 3, 0,
             16'h00FF, 16'h0F0F, 0, 0);
    runFrame("atload", 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    runFrame("new00FF", 16'h00FF, 1'b1, 16'h0F0F, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);

    // Enable drop at bit 10: frame completes, then idle.
    runFrame("endrop", 16'h00FF, 1'b1, 16'h0F0F, 1'b1, 1'b0, 4, 10, 0, 0, 0, 0);
    checkIdle("after drop", 20);

    // Reset at bit 7, then restart: holding registers back at 0x8000.
    enable = 1'b1;
    applyStimulus();
    runFrame("rst", 16'h00FF, 1'b1, 16'h0F0F, 1'b1, 1'b0, 5, 7, 0, 0, 0, 0);
    enable = 1'b0;
    applyStimulus();
    reset = 1'b0;
    checkIdle("post reset", 10);
    enable = 1'b1;
    applyStimulus();
    runFrame("restart", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
